// File: rtl/ara_xif_issue_tracker.sv
// ara_xif_issue_tracker: XIF issue/register/commit front end feeding Ara's XIF ring buffer.
// Optional ID protocol checking on error_o is enabled by defining ARA_XIF_ID_CHECK_EN.
package ara_xif_issue_tracker_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [1:0]  rs_valid;
    logic [2:0]  frm;
  } entry_t;
endpackage

module ara_xif_issue_tracker #(
  parameter int unsigned ID_WIDTH = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 64,
  parameter type         dtype    = ara_xif_issue_tracker_pkg::entry_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]         issue_instr_i,
  input  logic                reg_valid_i,
  output logic                reg_ready_o,
  input  logic [ID_WIDTH-1:0] reg_id_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic [1:0]          rs_valid_i,
  input  logic [2:0]          frm_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  input  logic                retire_i,
  input  logic [ID_WIDTH-1:0] retire_id_i,
  input  logic                buf_full_i,
  output logic                push_o,
  output logic [ID_WIDTH-1:0] id_o,
  output dtype                data_o,
  output logic                register_valid_o,
  output logic [ID_WIDTH-1:0] reg_id_o,
  output logic [XLEN-1:0]     rs1_o,
  output logic [XLEN-1:0]     rs2_o,
  output logic [1:0]          rs_valid_o,
  output logic [2:0]          frm_o,
  output logic                commit_o,
  output logic [ID_WIDTH-1:0] commit_id_o,
  output logic                flush_o,
  output logic                error_o
);
  localparam int unsigned NID        = 1 << ID_WIDTH;
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW         = ADDR_DEPTH + 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e              r_state, w_state_n;
  logic                w_run;
  logic [NID-1:0]      r_inf, r_cmt, w_inf_n, w_cmt_n;
  logic [CW-1:0]       r_count, w_count_n;
  logic [ID_WIDTH:0]   w_pop;
  logic                w_kill_req, w_issue_hs, w_reg_hs;
  logic                w_cmt_ok, w_ret_ok, w_commit, w_kill, w_retire;
  dtype                w_data;

  assign w_kill_req = commit_valid_i & commit_kill_i;
  assign issue_ready_o = w_run & (r_count < CW'(DEPTH)) & ~buf_full_i & ~w_kill_req;
  assign w_issue_hs = issue_valid_i & issue_ready_o;
  // Operands wait until the buffer has seen the push that links the ID to a slot.
  assign reg_ready_o = w_run & r_inf[reg_id_i]
                     & ~(w_issue_hs & (reg_id_i == issue_id_i))
                     & ~(push_o & (reg_id_i == id_o));
  assign w_reg_hs = reg_valid_i & reg_ready_o;

`ifdef ARA_XIF_ID_CHECK_EN
  logic [2:0] r_bad;
  logic       w_bad, w_err, r_error;
  assign w_cmt_ok = r_inf[commit_id_i];
  assign w_ret_ok = r_inf[retire_id_i];
  assign w_bad    = reg_valid_i & ~r_inf[reg_id_i];
  assign w_err    = (w_issue_hs & r_inf[issue_id_i]) | (commit_valid_i & ~w_cmt_ok)
                  | (retire_i & ~w_ret_ok) | (w_bad & (r_bad == 3'd3));
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bad   <= '0;
      r_error <= 1'b0;
    end else begin
      r_bad   <= w_bad ? ((r_bad == 3'd4) ? r_bad : r_bad + 3'd1) : 3'd0;
      r_error <= w_err;
    end
  end
  assign error_o = r_error;
`else
  assign w_cmt_ok = 1'b1;
  assign w_ret_ok = 1'b1;
  assign error_o  = 1'b0;
`endif

  assign w_commit = commit_valid_i & ~commit_kill_i & w_cmt_ok;
  assign w_kill   = w_kill_req & w_cmt_ok;
  assign w_retire = retire_i & w_ret_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      RUN:     if (w_kill) w_state_n = FLUSH;
      FLUSH:   w_state_n = RUN;
      default: w_state_n = RUN;
    endcase
  end

  always_comb begin
    w_run = (r_state == RUN);
  end

  // Order matters: commit, then retire, then kill, then a fresh issue reuses the ID.
  always_comb begin
    w_inf_n = r_inf;
    w_cmt_n = r_cmt;
    if (w_commit) w_cmt_n[commit_id_i] = 1'b1;
    if (w_retire) begin
      w_inf_n[retire_id_i] = 1'b0;
      w_cmt_n[retire_id_i] = 1'b0;
    end
    if (w_kill) w_inf_n = w_inf_n & w_cmt_n;
    if (w_issue_hs) begin
      w_inf_n[issue_id_i] = 1'b1;
      w_cmt_n[issue_id_i] = 1'b0;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NID; i++) w_pop = w_pop + {{ID_WIDTH{1'b0}}, w_inf_n[i] & w_cmt_n[i]};
  end

  always_comb begin
    w_count_n = r_count;
    if (w_kill) begin
      w_count_n = (w_pop > (ID_WIDTH + 1)'(DEPTH)) ? CW'(DEPTH) : CW'(w_pop);
    end else if (w_issue_hs && !w_retire) begin
      w_count_n = (r_count == CW'(DEPTH)) ? r_count : r_count + CW'(1);
    end else if (!w_issue_hs && w_retire) begin
      w_count_n = (r_count == '0) ? r_count : r_count - CW'(1);
    end
  end

  always_comb begin
    w_data       = '0;
    w_data.instr = issue_instr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inf            <= '0;
      r_cmt            <= '0;
      r_count          <= '0;
      push_o           <= 1'b0;
      id_o             <= '0;
      data_o           <= '0;
      register_valid_o <= 1'b0;
      reg_id_o         <= '0;
      rs1_o            <= '0;
      rs2_o            <= '0;
      rs_valid_o       <= '0;
      frm_o            <= '0;
      commit_o         <= 1'b0;
      flush_o          <= 1'b0;
      commit_id_o      <= '0;
    end else begin
      r_inf            <= w_inf_n;
      r_cmt            <= w_cmt_n;
      r_count          <= w_count_n;
      push_o           <= w_issue_hs;
      register_valid_o <= w_reg_hs;
      commit_o         <= w_commit;
      flush_o          <= w_kill;
      if (w_issue_hs) begin
        id_o   <= issue_id_i;
        data_o <= w_data;
      end
      if (w_reg_hs) begin
        reg_id_o   <= reg_id_i;
        rs1_o      <= rs1_i;
        rs2_o      <= rs2_i;
        rs_valid_o <= rs_valid_i;
        frm_o      <= frm_i;
      end
      if (w_commit || w_kill) commit_id_o <= commit_id_i;
    end
  end
endmodule

// File: tb/tb_ara_xif_issue_tracker.sv
// Bench for ara_xif_issue_tracker: directed scenarios plus random traffic against a scoreboard model.
module tb_ara_xif_issue_tracker;
  localparam int DEPTH = 4;
  typedef ara_xif_issue_tracker_pkg::entry_t entry_t;

  logic        clk_i = 1'b0, rst_ni;
  logic        issue_valid_i, issue_ready_o, reg_valid_i, reg_ready_o;
  logic [7:0]  issue_id_i, reg_id_i, commit_id_i, retire_id_i;
  logic [31:0] issue_instr_i;
  logic [63:0] rs1_i, rs2_i, rs1_o, rs2_o;
  logic [1:0]  rs_valid_i, rs_valid_o;
  logic [2:0]  frm_i, frm_o;
  logic        commit_valid_i, commit_kill_i, retire_i, buf_full_i;
  logic        push_o, register_valid_o, commit_o, flush_o, error_o;
  logic [7:0]  id_o, reg_id_o, commit_id_o;
  entry_t      data_o;

  int n_chk = 0, n_fail = 0;

  ara_xif_issue_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_instr_i(issue_instr_i),
    .reg_valid_i(reg_valid_i), .reg_ready_o(reg_ready_o), .reg_id_i(reg_id_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs_valid_i(rs_valid_i), .frm_i(frm_i),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .retire_i(retire_i), .retire_id_i(retire_id_i), .buf_full_i(buf_full_i),
    .push_o(push_o), .id_o(id_o), .data_o(data_o),
    .register_valid_o(register_valid_o), .reg_id_o(reg_id_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rs_valid_o(rs_valid_o), .frm_o(frm_o),
    .commit_o(commit_o), .commit_id_o(commit_id_o), .flush_o(flush_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef ARA_XIF_ID_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  // Reference model: per-ID flags, an in-flight count, and the outputs expected after each edge.
  bit          m_inf[256], m_cmt[256];
  int          m_cnt, m_bad;
  bit          m_flush;
  bit          e_push, e_regv, e_commit, e_flush, e_err;
  logic [7:0]  e_id, e_rid, e_cid;
  entry_t      e_data;
  logic [63:0] e_rs1, e_rs2;
  logic [1:0]  e_rsv;
  logic [2:0]  e_frm;

  function automatic bit f_iready();
    return !m_flush && (m_cnt < DEPTH) && !buf_full_i && !(commit_valid_i && commit_kill_i);
  endfunction

  function automatic bit f_rready();
    bit ihs;
    ihs = issue_valid_i && f_iready();
    return !m_flush && m_inf[reg_id_i] && !(ihs && reg_id_i == issue_id_i)
           && !(e_push && reg_id_i == e_id);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 256; i++) begin m_inf[i] = 0; m_cmt[i] = 0; end
    m_cnt = 0; m_bad = 0; m_flush = 0;
    e_push = 0; e_regv = 0; e_commit = 0; e_flush = 0; e_err = 0;
    e_id = 0; e_rid = 0; e_cid = 0; e_data = '0;
    e_rs1 = 0; e_rs2 = 0; e_rsv = 0; e_frm = 0;
  endtask

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) m_reset();
    else begin
      bit ihs, rhs, cok, rok, kill;
      int pop;
      ihs = issue_valid_i && f_iready();
      rhs = reg_valid_i && f_rready();
      cok = CHECK ? m_inf[commit_id_i] : 1'b1;
      rok = CHECK ? m_inf[retire_id_i] : 1'b1;
      if (reg_valid_i && !m_inf[reg_id_i]) m_bad++; else m_bad = 0;
      e_err = CHECK && ((ihs && m_inf[issue_id_i]) || (commit_valid_i && !cok)
                        || (retire_i && !rok) || m_bad == 4);
      kill = commit_valid_i && commit_kill_i && cok;
      e_push = ihs;
      if (ihs) begin e_id = issue_id_i; e_data = '0; e_data.instr = issue_instr_i; end
      e_regv = rhs;
      if (rhs) begin e_rid = reg_id_i; e_rs1 = rs1_i; e_rs2 = rs2_i; e_rsv = rs_valid_i; e_frm = frm_i; end
      e_commit = commit_valid_i && !commit_kill_i && cok;
      e_flush = kill;
      if (e_commit || kill) e_cid = commit_id_i;
      if (e_commit) m_cmt[commit_id_i] = 1;
      if (retire_i && rok) begin m_inf[retire_id_i] = 0; m_cmt[retire_id_i] = 0; end
      if (kill) for (int i = 0; i < 256; i++) if (!m_cmt[i]) m_inf[i] = 0;
      if (ihs) begin m_inf[issue_id_i] = 1; m_cmt[issue_id_i] = 0; end
      if (kill) begin
        pop = 0;
        for (int i = 0; i < 256; i++) pop += int'(m_inf[i] && m_cmt[i]);
        m_cnt = (pop > DEPTH) ? DEPTH : pop;
      end else begin
        m_cnt = m_cnt + int'(ihs) - int'(retire_i && rok);
        if (m_cnt < 0) m_cnt = 0;
        if (m_cnt > DEPTH) m_cnt = DEPTH;
      end
      m_flush = !m_flush && kill;
    end
  end

  always @(negedge clk_i) begin
    chk("issue_ready", issue_ready_o, f_iready());
    chk("reg_ready", reg_ready_o, f_rready());
    chk("push", {push_o, id_o, data_o}, {e_push, e_id, e_data});
    chk("regwr", {register_valid_o, reg_id_o, rs_valid_o, frm_o}, {e_regv, e_rid, e_rsv, e_frm});
    chk("rs12", {rs1_o, rs2_o}, {e_rs1, e_rs2});
    chk("commit", {commit_o, flush_o, commit_id_o}, {e_commit, e_flush, e_cid});
    chk("error", error_o, e_err);
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_id_i = 0; issue_instr_i = 0;
    reg_valid_i = 0; reg_id_i = 0; rs1_i = 0; rs2_i = 0; rs_valid_i = 0; frm_i = 0;
    commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    retire_i = 0; retire_id_i = 0; buf_full_i = 0;
  endtask

  task automatic issue(input logic [7:0] id);
    issue_valid_i = 1; issue_id_i = id; issue_instr_i = {24'hA5A5A5, id};
    cyc();
    issue_valid_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    idle();
    repeat (3) cyc();
    chk("rst_outs", {push_o, register_valid_o, commit_o, flush_o, error_o}, 5'b0);
    chk("rst_ready", {issue_ready_o, reg_ready_o}, 2'b10);
    rst_ni = 1;

    // Back-to-back issues fill the four slots.
    for (int k = 0; k < 4; k++) begin
      issue_valid_i = 1; issue_id_i = 8'(3 + 2 * k); issue_instr_i = 32'h1000 + k;
      cyc();
      chk("t1_push", {push_o, id_o, data_o.instr}, {1'b1, 8'(3 + 2 * k), 32'h1000 + k});
    end
    issue_id_i = 8'd11; #1;
    chk("t1_full", issue_ready_o, 1'b0);
    cyc();
    chk("t1_nopush", push_o, 1'b0);
    issue_valid_i = 0; retire_i = 1; retire_id_i = 8'd3; #1;
    chk("t1_full_ret", issue_ready_o, 1'b0);
    cyc();
    retire_i = 0; #1;
    chk("t1_free", issue_ready_o, 1'b1);

    // Operand write for an ID issued in the same cycle waits two cycles.
    retire_i = 1; retire_id_i = 8'd5; cyc(); retire_i = 0;
    issue_valid_i = 1; issue_id_i = 8'd5; issue_instr_i = 32'h55;
    reg_valid_i = 1; reg_id_i = 8'd5; rs1_i = 64'hDEAD; rs2_i = 64'hBEEF; rs_valid_i = 2'b11; frm_i = 3'd2;
    #1; chk("t2_rdy0", reg_ready_o, 1'b0);
    cyc(); issue_valid_i = 0; #1;
    chk("t2_rdy1", {reg_ready_o, push_o, id_o}, {1'b0, 1'b1, 8'd5});
    cyc();
    chk("t2_rdy2", reg_ready_o, 1'b1);
    cyc(); reg_valid_i = 0;
    chk("t2_write", {register_valid_o, reg_id_o, rs1_o}, {1'b1, 8'd5, 64'hDEAD});

    // Commit 9, then kill 5 while 5 and 7 are uncommitted.
    commit_valid_i = 1; commit_id_i = 8'd9; cyc(); commit_valid_i = 0;
    chk("t3_commit", {commit_o, commit_id_o}, {1'b1, 8'd9});
    commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 8'd5; issue_valid_i = 1; issue_id_i = 8'd20;
    #1; chk("t3_kill_rdy", issue_ready_o, 1'b0);
    cyc(); commit_valid_i = 0; commit_kill_i = 0; #1;
    chk("t3_flush", {flush_o, commit_id_o, push_o, issue_ready_o, reg_ready_o}, {1'b1, 8'd5, 1'b0, 1'b0, 1'b0});
    issue_valid_i = 0;
    cyc();
    chk("t3_run", {flush_o, issue_ready_o}, 2'b01);
    issue(8'd1); issue(8'd2); issue(8'd4);
    issue_valid_i = 1; issue_id_i = 8'd12; #1;
    chk("t3_count1", issue_ready_o, 1'b0);
    issue_valid_i = 0;

    // Issue, retire and commit in one cycle at count 2.
    retire_i = 1; retire_id_i = 8'd9; cyc(); retire_id_i = 8'd1; cyc(); retire_i = 0;
    issue_valid_i = 1; issue_id_i = 8'd6; retire_i = 1; retire_id_i = 8'd2;
    commit_valid_i = 1; commit_id_i = 8'd4;
    cyc(); idle();
    chk("t4_both", {push_o, id_o, commit_o, commit_id_o}, {1'b1, 8'd6, 1'b1, 8'd4});
    issue(8'd10);
    issue_valid_i = 1; issue_id_i = 8'd11; #1;
    chk("t4_cnt3", issue_ready_o, 1'b1);
    cyc(); issue_valid_i = 0; #1;
    chk("t4_cnt4", issue_ready_o, 1'b0);

    // Protocol errors.
    retire_i = 1; retire_id_i = 8'd10; cyc(); retire_i = 0;
    issue(8'd6);
    chk("t5_reissue", {push_o, error_o}, {1'b1, CHECK});
    cyc();
    chk("t5_pulse", error_o, 1'b0);
    commit_valid_i = 1; commit_id_i = 8'd200; cyc(); commit_valid_i = 0;
    chk("t5_badcmt", {error_o, commit_o}, {CHECK, !CHECK});
    reg_valid_i = 1; reg_id_i = 8'd99;
    repeat (3) cyc();
    chk("t5_reg3", error_o, 1'b0);
    cyc();
    chk("t5_reg4", error_o, CHECK);
    cyc(); reg_valid_i = 0;
    chk("t5_reg5", error_o, 1'b0);

    // Reset while flushing.
    commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 8'd11; cyc(); idle();
    chk("t6_flush", flush_o, 1'b1);
    rst_ni = 0; #1;
    chk("t6_rst", {push_o, flush_o, commit_o, register_valid_o, error_o, issue_ready_o}, 6'b000001);
    cyc(); rst_ni = 1;
    issue(8'd1); issue(8'd2); issue(8'd3);
    issue_valid_i = 1; issue_id_i = 8'd4; #1;
    chk("t6_cnt", issue_ready_o, 1'b1);
    cyc(); issue_valid_i = 0; #1;
    chk("t6_full", issue_ready_o, 1'b0);

    // Random traffic on a small ID space so collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      issue_valid_i  = ($urandom_range(1) == 0);
      issue_id_i     = 8'($urandom_range(7));
      issue_instr_i  = $urandom;
      reg_valid_i    = ($urandom_range(4) < 2);
      reg_id_i       = 8'($urandom_range(7));
      rs1_i          = {$urandom, $urandom};
      rs2_i          = {$urandom, $urandom};
      rs_valid_i     = 2'($urandom_range(3));
      frm_i          = 3'($urandom_range(7));
      commit_valid_i = ($urandom_range(4) == 0);
      commit_kill_i  = ($urandom_range(3) == 0);
      commit_id_i    = 8'($urandom_range(7));
      retire_i       = ($urandom_range(3) == 0);
      retire_id_i    = 8'($urandom_range(7));
      buf_full_i     = ($urandom_range(9) == 0);
      rst_ni         = ($urandom_range(499) != 0);
      cyc();
    end
    rst_ni = 1; idle();
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
